muldiv_seq: RTL

- Sequencer for the iterative mult and div units and the Hi/Lo registers.
- Handshakes with the main control unit: accepts one start pulse, runs the selected unit for a fixed cycle count, then commits Hi/Lo.
- Drives the div operand-select muxes, including the memory-operand divide variant (divm).
- Raises a one-cycle divide-by-zero exception pulse.

---
 rtl/muldiv_seq_pkg.sv | 26 ++
 rtl/muldiv_seq_counter.sv | 34 +++
 rtl/muldiv_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the mult/div sequencer.
//   md_state_t      : 4-bit FSM state encoding (also visible on fsm_state)
//   MD_DIV/MD_MULT  : values driven on md_select (Hi/Lo source mux)
//   SEL_REG/SEL_MDR : values driven on div_a_sel / div_b_sel
package muldiv_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_M_START   = 4'd1,
      ST_M_RUN     = 4'd2,
      ST_D_LOAD    = 4'd3,
      ST_DM_WAIT_A = 4'd4,
      ST_DM_WAIT_B = 4'd5,
      ST_D_CHECK   = 4'd6,
      ST_D_RUN     = 4'd7,
      ST_WB        = 4'd8,
      ST_EXC       = 4'd9
   } md_state_t;

   localparam logic MD_DIV  = 1'b0;
   localparam logic MD_MULT = 1'b1;

   localparam logic SEL_REG = 1'b0;
   localparam logic SEL_MDR = 1'b1;

endpackage

// File: rtl/muldiv_seq_counter.sv
// md_cycle_counter: iteration counter shared by the mult and div phases.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronously reload the count with zero (wins over enable)
//   enable     : advance the count by one
//   limit      : runtime terminal value (number of run cycles minus one)
//   terminal   : high while the current count equals limit
module md_cycle_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + ONE;
      end
   end

   assign terminal = (count == limit);

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the iterative mult/div units and Hi/Lo registers.
//   clk, reset            : clock, asynchronous active-low reset
//   start_mult/div/divm   : single-cycle start pulses from the main control
//   op_valid              : divm only, MDR holds the next operand this cycle
//   div_b_in              : divider B-operand mux output (zero check)
//   mult_ctrl             : mult unit start strobe
//   div_a_write/b_write   : divider operand loads
//   div_a_sel/div_b_sel   : divider operand source (SEL_REG / SEL_MDR)
//   md_select             : Hi/Lo source (MD_MULT / MD_DIV), held for the op
//   hi_write/lo_write     : Hi/Lo write enables
//   busy, done, div_zero  : status; done and div_zero are one-cycle pulses
//   fsm_state             : current FSM state for observation
//
// Handshake: the start pulses are only honoured in IDLE (mult > div > divm)
// and need no acknowledge; busy tells the control unit a request is in
// flight. In the divm wait states op_valid acts as a valid with an implicit
// ready: each cycle op_valid is high consumes one MDR operand.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic        start_divm,
   input  logic        op_valid,
   input  logic [31:0] div_b_in,
   output logic        mult_ctrl,
   output logic        div_a_write,
   output logic        div_b_write,
   output logic        div_a_sel,
   output logic        div_b_sel,
   output logic        md_select,
   output logic        hi_write,
   output logic        lo_write,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [3:0]  fsm_state
);

   // Terminal values are run-length minus one since the counter starts at 0.
   // A divm operand arrives through the MDR path one cycle later than a
   // register operand, so its divide phase runs one extra cycle.
   localparam logic [CNT_W-1:0] MULT_LIMIT = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LIMIT  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIVM_LIMIT = CNT_W'(DIV_CYCLES);

   md_state_t        state;
   logic             zero_flag;
   logic             is_divm;
   logic             cnt_clear;
   logic             cnt_enable;
   logic             cnt_term;
   logic [CNT_W-1:0] cnt_limit;

   assign fsm_state = state;

   // Operand loads follow op_valid directly in the divm wait states.
   assign div_a_write = (state == ST_D_LOAD) || ((state == ST_DM_WAIT_A) && op_valid);
   assign div_b_write = (state == ST_D_LOAD) || ((state == ST_DM_WAIT_B) && op_valid);

   assign cnt_clear  = (state == ST_M_START) || (state == ST_D_CHECK);
   assign cnt_enable = (state == ST_M_RUN) || (state == ST_D_RUN);

   always_comb begin
      cnt_limit = DIV_LIMIT;
      if (state == ST_M_RUN) begin
         cnt_limit = MULT_LIMIT;
      end else if (is_divm) begin
         cnt_limit = DIVM_LIMIT;
      end
   end

   md_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (cnt_enable),
      .limit    (cnt_limit),
      .terminal (cnt_term)
   );

   // Registered outputs are assigned alongside the transition into the state
   // they belong to, so they are valid for the whole cycle of that state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         zero_flag <= 1'b0;
         is_divm   <= 1'b0;
         mult_ctrl <= 1'b0;
         div_a_sel <= SEL_REG;
         div_b_sel <= SEL_REG;
         md_select <= MD_DIV;
         hi_write  <= 1'b0;
         lo_write  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         mult_ctrl <= 1'b0;
         div_a_sel <= SEL_REG;
         div_b_sel <= SEL_REG;
         hi_write  <= 1'b0;
         lo_write  <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_mult) begin
                  state     <= ST_M_START;
                  mult_ctrl <= 1'b1;
                  md_select <= MD_MULT;
                  busy      <= 1'b1;
                  is_divm   <= 1'b0;
               end else if (start_div) begin
                  state     <= ST_D_LOAD;
                  md_select <= MD_DIV;
                  busy      <= 1'b1;
                  is_divm   <= 1'b0;
               end else if (start_divm) begin
                  state     <= ST_DM_WAIT_A;
                  div_a_sel <= SEL_MDR;
                  md_select <= MD_DIV;
                  busy      <= 1'b1;
                  is_divm   <= 1'b1;
               end
            end
            ST_M_START: begin
               state <= ST_M_RUN;
            end
            ST_M_RUN, ST_D_RUN: begin
               if (cnt_term) begin
                  state    <= ST_WB;
                  hi_write <= 1'b1;
                  lo_write <= 1'b1;
                  done     <= 1'b1;
               end
            end
            ST_D_LOAD: begin
               zero_flag <= (div_b_in == 32'd0);
               state     <= ST_D_CHECK;
            end
            ST_DM_WAIT_A: begin
               if (op_valid) begin
                  state     <= ST_DM_WAIT_B;
                  div_b_sel <= SEL_MDR;
               end else begin
                  div_a_sel <= SEL_MDR;
               end
            end
            ST_DM_WAIT_B: begin
               if (op_valid) begin
                  zero_flag <= (div_b_in == 32'd0);
                  state     <= ST_D_CHECK;
               end else begin
                  div_b_sel <= SEL_MDR;
               end
            end
            ST_D_CHECK: begin
               if (zero_flag) begin
                  state    <= ST_EXC;
                  div_zero <= 1'b1;
               end else begin
                  state <= ST_D_RUN;
               end
            end
            default: begin
               // WB, EXC and any unused encoding return to IDLE.
               state     <= ST_IDLE;
               busy      <= 1'b0;
               md_select <= MD_DIV;
            end
         endcase
      end
   end

endmodule
